// File: rtl/sqrt_sched_pkg.sv
// ---------------------------------------------------------------------------
// sqrt_pkg
// Shared definitions for the square-root scheduler slice.
//   SQRT_N / SQRT_R : default root width and requester count
//   RAD_W / REM_W   : radicand width (2N) and remainder width (N+1)
//   PTR_W           : width of requester indices and the round-robin pointer
//   schedState_t    : scheduler FSM state encoding
//   nextPtr()       : advances a requester index by one, wrapping at numReq
// ---------------------------------------------------------------------------
package sqrt_pkg;

   localparam int SQRT_N = 16;
   localparam int SQRT_R = 4;
   localparam int RAD_W  = 2 * SQRT_N;
   localparam int REM_W  = SQRT_N + 1;
   localparam int PTR_W  = 3;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LAUNCH  = 3'd1,
      WAIT_LO = 3'd2,
      WAIT_HI = 3'd3,
      RESP    = 3'd4
   } schedState_t;

   // Requester indices never exceed numReq-1, so an equality test is enough
   // to detect the wrap point.
   function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] ptr,
                                                input int numReq);
      if (ptr == PTR_W'(numReq - 1)) begin
         return '0;
      end
      return ptr + PTR_W'(1);
   endfunction

endpackage

// File: rtl/sqrt_sched_if.sv
// ---------------------------------------------------------------------------
// sqrt_sched_if
// Request/response bundle between the arithmetic clients and sqrt_sched.
//   reqValid/reqData/reqReady : per-requester radicand handshake
//   rspValid/rspReady         : per-requester result handshake
//   rspRoot/rspRem            : result of the current response
//   busy/doneCnt              : scheduler status
// master = client side, slave = scheduler side.
// ---------------------------------------------------------------------------
interface sqrt_sched_if
   import sqrt_pkg::*;
#(
   parameter int N = SQRT_N,
   parameter int R = SQRT_R
);

   logic [R-1:0]       reqValid;
   logic [R*2*N-1:0]   reqData;
   logic [R-1:0]       reqReady;
   logic [R-1:0]       rspValid;
   logic [R-1:0]       rspReady;
   logic [N-1:0]       rspRoot;
   logic [N:0]         rspRem;
   logic               busy;
   logic [15:0]        doneCnt;

   modport master (
      output reqValid, reqData, rspReady,
      input  reqReady, rspValid, rspRoot, rspRem, busy, doneCnt
   );

   modport slave (
      input  reqValid, reqData, rspReady,
      output reqReady, rspValid, rspRoot, rspRem, busy, doneCnt
   );

endinterface

// File: rtl/sqrt_core.sv
// ---------------------------------------------------------------------------
// sqrt_core
// Iterative digit-by-digit integer square root, one root bit per cycle.
//   clk, rst_n   : clock, asynchronous active-low reset
//   i_start      : sampled only while o_complete is high
//   i_radicand   : 2N-bit operand, sampled with i_start
//   o_complete   : high when idle / result valid; low while iterating
//   o_root       : N-bit floor(sqrt(radicand))
//   o_rem        : N+1-bit radicand - root*root
// Latency: the start edge loads the operand, then N further edges iterate;
// o_complete rises on the last of them. There is no early exit.
// ---------------------------------------------------------------------------
module sqrt_core
   import sqrt_pkg::*;
#(
   parameter int N = SQRT_N
)
(
   input  logic           clk,
   input  logic           rst_n,
   input  logic           i_start,
   input  logic [2*N-1:0] i_radicand,
   output logic           o_complete,
   output logic [N-1:0]   o_root,
   output logic [N:0]     o_rem
);

   localparam int CNT_W = $clog2(N + 1);

   logic [2*N-1:0]   r_x;
   logic [N-1:0]     r_root;
   logic [N:0]       r_rem;
   logic [CNT_W-1:0] r_cnt;
   logic             r_complete;
   logic [N+3:0]     w_trial;
   logic             w_trialNeg;

   // Trial subtraction: bring down the next two radicand bits and try to
   // subtract (4*root + 1). One extra top bit holds the sign of the attempt.
   always_comb begin
      w_trial    = {1'b0, r_rem, r_x[2*N-1 -: 2]} - {2'b00, r_root, 2'b01};
      w_trialNeg = w_trial[N+3];
   end

   // Iteration state. A failed trial keeps the shifted partial remainder;
   // its two dropped top bits are always zero in that case because the
   // remainder never exceeds 2*root.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_x        <= '0;
         r_root     <= '0;
         r_rem      <= '0;
         r_cnt      <= '0;
         r_complete <= 1'b1;
      end else if (r_complete) begin
         if (i_start) begin
            r_x        <= i_radicand;
            r_root     <= '0;
            r_rem      <= '0;
            r_cnt      <= '0;
            r_complete <= 1'b0;
         end
      end else begin
         r_x <= {r_x[2*N-3:0], 2'b00};
         if (!w_trialNeg) begin
            r_rem  <= w_trial[N:0];
            r_root <= {r_root[N-2:0], 1'b1};
         end else begin
            r_rem  <= {r_rem[N-2:0], r_x[2*N-1 -: 2]};
            r_root <= {r_root[N-2:0], 1'b0};
         end
         if (r_cnt == CNT_W'(N - 1)) begin
            r_complete <= 1'b1;
         end else begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

   assign o_complete = r_complete;
   assign o_root     = r_root;
   assign o_rem      = r_rem;

endmodule

// File: rtl/sqrt_sched_arbiter.sv
// ---------------------------------------------------------------------------
// sqrt_rr_arbiter
// Combinational round-robin arbiter. The search begins at i_ptr and walks
// upward with wrap; the first pending request wins.
//   i_req      : pending request per requester
//   i_ptr      : highest-priority requester index
//   i_enable   : when low no grant is produced
//   o_grant    : one-hot grant
//   o_grantIdx : binary index of the granted requester
// ---------------------------------------------------------------------------
module sqrt_rr_arbiter
   import sqrt_pkg::*;
#(
   parameter int R = SQRT_R
)
(
   input  logic [R-1:0]     i_req,
   input  logic [PTR_W-1:0] i_ptr,
   input  logic             i_enable,
   output logic [R-1:0]     o_grant,
   output logic [PTR_W-1:0] o_grantIdx
);

   // Walk the candidates in priority order starting from the pointer. Each
   // candidate index is turned into a one-hot mask so the request vector is
   // never indexed by a computed value.
   always_comb begin
      logic [PTR_W-1:0] cur;
      logic [R-1:0]     sel;
      logic             found;
      o_grant    = '0;
      o_grantIdx = '0;
      cur        = i_ptr;
      sel        = '0;
      found      = 1'b0;
      for (int k = 0; k < R; k++) begin
         for (int i = 0; i < R; i++) begin
            sel[i] = (cur == PTR_W'(i));
         end
         if (i_enable && !found && (|(i_req & sel))) begin
            found      = 1'b1;
            o_grant    = sel;
            o_grantIdx = cur;
         end
         cur = nextPtr(cur, R);
      end
   end

endmodule

// File: rtl/sqrt_sched.sv
// ---------------------------------------------------------------------------
// sqrt_sched
// Round-robin scheduler sharing one iterative sqrt core among R requesters.
//   clk, rst_n : clock, asynchronous active-low reset (also resets the core)
//   bus        : sqrt_sched_if slave port
//                reqValid/reqData in, reqReady out (one-hot accept strobe)
//                rspValid out (one-hot), rspReady in
//                rspRoot/rspRem out (registered result)
//                busy out (state != IDLE), doneCnt out (completed responses)
// One transaction is in flight at a time; IDLE is visited for one cycle
// between transactions and that cycle performs the next accept.
// ---------------------------------------------------------------------------
module sqrt_sched
   import sqrt_pkg::*;
#(
   parameter int N = SQRT_N,
   parameter int R = SQRT_R
)
(
   input  logic        clk,
   input  logic        rst_n,
   sqrt_sched_if.slave bus
);

   localparam int RADW = 2 * N;

   schedState_t      r_state;
   schedState_t      w_nextState;
   logic [PTR_W-1:0] r_ptr;
   logic [PTR_W-1:0] r_grantIdx;
   logic [RADW-1:0]  r_operand;
   logic [N-1:0]     r_rspRoot;
   logic [N:0]       r_rspRem;
   logic [15:0]      r_doneCnt;

   logic [R-1:0]     w_grant;
   logic [PTR_W-1:0] w_grantIdx;
   logic [R-1:0]     w_grantSel;
   logic [RADW-1:0]  w_reqSel;
   logic             w_arbEnable;
   logic             w_accept;
   logic             w_handshake;
   logic             w_coreStart;
   logic             w_coreComplete;
   logic [N-1:0]     w_coreRoot;
   logic [N:0]       w_coreRem;

   // Arbitration is only allowed in IDLE. rst_n is folded in so reqReady
   // is forced low for the whole time reset is held, not just after an edge.
   assign w_arbEnable = (r_state == IDLE) && rst_n;

   sqrt_rr_arbiter #(.R(R)) u_arbiter (
      .i_req      (bus.reqValid),
      .i_ptr      (r_ptr),
      .i_enable   (w_arbEnable),
      .o_grant    (w_grant),
      .o_grantIdx (w_grantIdx)
   );

   assign w_accept = |w_grant;

   // One-hot view of the latched grantee, used both to present rspValid and
   // to ignore rspReady bits belonging to other requesters.
   always_comb begin
      w_grantSel = '0;
      for (int i = 0; i < R; i++) begin
         w_grantSel[i] = (r_grantIdx == PTR_W'(i));
      end
   end

   assign w_handshake = (r_state == RESP) && (|(bus.rspReady & w_grantSel));

   // Operand mux driven by the one-hot grant; all-zero when nothing is granted.
   always_comb begin
      w_reqSel = '0;
      for (int i = 0; i < R; i++) begin
         if (w_grant[i]) begin
            w_reqSel = bus.reqData[i*RADW +: RADW];
         end
      end
   end

   sqrt_core #(.N(N)) u_core (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_start    (w_coreStart),
      .i_radicand (r_operand),
      .o_complete (w_coreComplete),
      .o_root     (w_coreRoot),
      .o_rem      (w_coreRem)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state logic. The core reports complete=1 out of reset, so a result
   // is only trusted after seeing complete fall (WAIT_LO) and then rise
   // again (WAIT_HI).
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE:    if (w_accept)        w_nextState = LAUNCH;
         LAUNCH:                       w_nextState = WAIT_LO;
         WAIT_LO: if (!w_coreComplete) w_nextState = WAIT_HI;
         WAIT_HI: if (w_coreComplete)  w_nextState = RESP;
         RESP:    if (w_handshake)     w_nextState = IDLE;
         default:                      w_nextState = IDLE;
      endcase
   end

   // Outputs decoded from the current state.
   always_comb begin
      w_coreStart  = (r_state == LAUNCH);
      bus.reqReady = w_grant;
      bus.rspValid = (r_state == RESP) ? w_grantSel : '0;
      bus.busy     = (r_state != IDLE);
   end

   // Datapath registers: latch grantee and operand on accept, capture the
   // core result when complete rises, and on the response handshake bump
   // the completion counter and move priority past the served requester.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr      <= '0;
         r_grantIdx <= '0;
         r_operand  <= '0;
         r_rspRoot  <= '0;
         r_rspRem   <= '0;
         r_doneCnt  <= '0;
      end else begin
         if (w_accept) begin
            r_grantIdx <= w_grantIdx;
            r_operand  <= w_reqSel;
         end
         if ((r_state == WAIT_HI) && w_coreComplete) begin
            r_rspRoot <= w_coreRoot;
            r_rspRem  <= w_coreRem;
         end
         if (w_handshake) begin
            r_doneCnt <= r_doneCnt + 16'd1;
            r_ptr     <= nextPtr(r_grantIdx, R);
         end
      end
   end

   assign bus.rspRoot = r_rspRoot;
   assign bus.rspRem  = r_rspRem;
   assign bus.doneCnt = r_doneCnt;

endmodule
